reg_arbiter: RTL and testbench

REG_ARBITER -- requirements
Module: reg_arbiter

---
 rtl/reg_arbiter_if.sv | 24 ++
 rtl/reg_arbiter.sv | 111 +++++++++++
 tb/tb_reg_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_arbiter_if.sv
// Request/grant bus of the round-robin register arbiter.
// The LOCK signal exists only when ARB_LOCK_EN is defined.
interface reg_arbiter_if #(
    parameter int WIDTH = 4
);
    logic [3:0]         REQ;
    logic [4*WIDTH-1:0] DATA_IN;
`ifdef ARB_LOCK_EN
    logic               LOCK;
`endif
    logic [3:0]         GNT;
    logic [1:0]         OWNER;
    logic [WIDTH-1:0]   Q;
    logic               ACK;
    logic               BUSY;

`ifdef ARB_LOCK_EN
    modport master (output REQ, DATA_IN, LOCK, input GNT, OWNER, Q, ACK, BUSY);
    modport slave  (input REQ, DATA_IN, LOCK, output GNT, OWNER, Q, ACK, BUSY);
`else
    modport master (output REQ, DATA_IN, input GNT, OWNER, Q, ACK, BUSY);
    modport slave  (input REQ, DATA_IN, output GNT, OWNER, Q, ACK, BUSY);
`endif
endinterface

// File: rtl/reg_arbiter.sv
// Four-requester round-robin arbiter guarding one shared storage register.
// A granted requester writes its data word into Q one cycle after the grant,
// ACK pulses for one cycle, and the grant is held until the owner drops REQ.
// Optional macro ARB_LOCK_EN adds LOCK: when high at release, the owner keeps
// top priority for the next arbitration instead of passing it on.
module reg_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic          CLK,
    input  logic          CLR,
    reg_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         gnt_q, gnt_d;
    logic [1:0]         owner_q, owner_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               ack_q, ack_d;
    logic [1:0]         win;

    // First requesting index found searching upward from ptr, wrapping 3->0.
    function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] sel;
        logic       found;
        sel   = ptr;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // State register; CLR clears everything at once, no clock needed.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            q_q     <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            q_q     <= q_d;
            ack_q   <= ack_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, write in XFER, hold until owner lets go.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        q_d     = q_q;
        ack_d   = 1'b0;
        win     = pick(bus.REQ, ptr_q);
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (|bus.REQ) begin
                    gnt_d   = 4'b0001 << win;
                    owner_d = win;
                    state_d = XFER;
                end
            end
            XFER: begin
                q_d     = bus.DATA_IN[owner_q*WIDTH +: WIDTH];
                ack_d   = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (!bus.REQ[owner_q]) begin
                    gnt_d   = '0;
                    state_d = IDLE;
`ifdef ARB_LOCK_EN
                    ptr_d   = bus.LOCK ? owner_q : owner_q + 2'd1;
`else
                    ptr_d   = owner_q + 2'd1;
`endif
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.GNT   = gnt_q;
    assign bus.OWNER = owner_q;
    assign bus.Q     = q_q;
    assign bus.ACK   = ack_q;
    assign bus.BUSY  = (state_q != IDLE);

endmodule

// File: tb/tb_reg_arbiter.sv
// Self-checking bench for reg_arbiter: directed scenarios plus randomized
// traffic, all compared against a transaction-level model of the arbiter.
module tb_reg_arbiter;
    localparam int W = 4;

    logic CLK = 1'b0;
    logic CLR = 1'b0;

    reg_arbiter_if #(.WIDTH(W)) bus ();

    reg_arbiter #(.WIDTH(W)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: an active transfer, its age in cycles, and the rotation start.
    bit             m_active;
    int             m_age;
    int             m_owner;
    int             m_ptr;
    logic [W-1:0]   m_q;
    bit             m_ack;

    logic [3:0]     cur_r;
    logic [4*W-1:0] cur_d;
    logic           cur_l;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_age    = 0;
        m_owner  = 0;
        m_ptr    = 0;
        m_q      = '0;
        m_ack    = 0;
    endtask

    task automatic model_update();
        if (!m_active) begin
            m_ack = 0;
            if (cur_r != 4'b0000) begin
                for (int i = 3; i >= 0; i--) begin
                    if (cur_r[(m_ptr + i) % 4]) m_owner = (m_ptr + i) % 4;
                end
                m_active = 1;
                m_age    = 0;
            end
        end else if (m_age == 0) begin
            m_q   = cur_d[m_owner*W +: W];
            m_ack = 1;
            m_age = 1;
        end else begin
            m_ack = 0;
            if (!cur_r[m_owner]) begin
                m_active = 0;
`ifdef ARB_LOCK_EN
                m_ptr = cur_l ? m_owner : (m_owner + 1) % 4;
`else
                m_ptr = (m_owner + 1) % 4;
`endif
            end
        end
    endtask

    task automatic compare_all();
        check("gnt",   32'(bus.GNT),   m_active ? (32'd1 << m_owner) : 32'd0);
        check("owner", 32'(bus.OWNER), m_owner);
        check("q",     32'(bus.Q),     32'(m_q));
        check("ack",   32'(bus.ACK),   32'(m_ack));
        check("busy",  32'(bus.BUSY),  32'(m_active));
    endtask

    task automatic tick();
        @(posedge CLK);
        model_update();
        @(negedge CLK);
        compare_all();
    endtask

    task automatic step(input logic [3:0] r, input logic [4*W-1:0] d, input logic l);
        cur_r = r;
        cur_d = d;
        cur_l = l;
        bus.REQ     = r;
        bus.DATA_IN = d;
`ifdef ARB_LOCK_EN
        bus.LOCK    = l;
`endif
        tick();
    endtask

    // Asynchronous clear pulse inside the low clock phase, then one clocked cycle.
    task automatic do_clr(input logic [3:0] r);
        cur_r   = r;
        bus.REQ = r;
        CLR     = 1'b1;
        #2;
        check("clr_gnt",  32'(bus.GNT),  32'd0);
        check("clr_q",    32'(bus.Q),    32'd0);
        check("clr_busy", 32'(bus.BUSY), 32'd0);
        check("clr_ack",  32'(bus.ACK),  32'd0);
        check("clr_own",  32'(bus.OWNER), 32'd0);
        model_reset();
        #1;
        CLR = 1'b0;
        tick();
    endtask

    int         grants[$];
    logic [3:0] prev_gnt;
    logic [3:0] r;
    logic [31:0] rnd;

    initial begin
        bus.REQ     = '0;
        bus.DATA_IN = '0;
`ifdef ARB_LOCK_EN
        bus.LOCK    = 1'b0;
`endif
        cur_r = '0;
        cur_d = '0;
        cur_l = 1'b0;
        model_reset();

        // Power-on clear and idle behaviour.
        #1 CLR = 1'b1;
        #2;
        check("rst_gnt",  32'(bus.GNT),   32'd0);
        check("rst_q",    32'(bus.Q),     32'd0);
        check("rst_own",  32'(bus.OWNER), 32'd0);
        check("rst_busy", 32'(bus.BUSY),  32'd0);
        check("rst_ack",  32'(bus.ACK),   32'd0);
        @(posedge CLK);
        @(negedge CLK);
        CLR = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(4'b0000, 16'h1234, 1'b0);
            check("idle_ack", 32'(bus.ACK), 32'd0);
        end

        // Single requester 2 with slice 2 = A, held four cycles.
        step(4'b0100, 16'h0A00, 1'b0);
        check("r29_gnt", 32'(bus.GNT), 32'h4);
        step(4'b0100, 16'h0A00, 1'b0);
        check("r29_q",   32'(bus.Q),   32'hA);
        check("r29_ack", 32'(bus.ACK), 32'd1);
        step(4'b0100, 16'h0500, 1'b0);
        check("r29_q2",  32'(bus.Q),   32'hA);
        step(4'b0100, 16'h0500, 1'b0);
        step(4'b0000, 16'h0500, 1'b0);
        check("r29_rel", 32'(bus.GNT), 32'd0);

        // Round-robin fairness with everyone requesting.
        do_clr(4'b0000);
        prev_gnt = '0;
        for (int c = 0; c < 60 && grants.size() < 5; c++) begin
            r = 4'hF;
            if (m_ack) r[m_owner] = 1'b0;
            rnd = $urandom;
            step(r, rnd[4*W-1:0], 1'b0);
            if (bus.GNT != 4'b0000 && prev_gnt == 4'b0000) grants.push_back(int'(bus.OWNER));
            prev_gnt = bus.GNT;
        end
        check("rr_count", grants.size(), 5);
        for (int i = 0; i < grants.size(); i++) check("rr_order", grants[i], i % 4);

        // Clear during owner-1 HOLD with requester 3 waiting.
        do_clr(4'b0000);
        step(4'b0010, 16'h00C0, 1'b0);
        step(4'b0010, 16'h00C0, 1'b0);
        step(4'b1010, 16'h00C0, 1'b0);
        check("r31_hold", 32'(bus.GNT), 32'h2);
        do_clr(4'b1000);
        check("r31_own", 32'(bus.OWNER), 32'd3);
        check("r31_gnt", 32'(bus.GNT),   32'h8);

`ifdef ARB_LOCK_EN
        // Lock keeps requester 0 on top; without lock the pointer moves on.
        do_clr(4'b0000);
        step(4'b0011, 16'h0021, 1'b0);
        step(4'b0011, 16'h0021, 1'b0);
        step(4'b0010, 16'h0021, 1'b1);
        step(4'b0011, 16'h0021, 1'b0);
        check("lock_keep", 32'(bus.OWNER), 32'd0);
        step(4'b0011, 16'h0021, 1'b0);
        step(4'b0010, 16'h0021, 1'b0);
        step(4'b0011, 16'h0021, 1'b0);
        check("lock_pass", 32'(bus.OWNER), 32'd1);
`endif

        // Randomized traffic with occasional clears.
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                rnd = $urandom;
                do_clr(rnd[3:0]);
            end else begin
                rnd = $urandom;
                if ($urandom_range(0, 99) < 35) r = rnd[3:0];
                rnd = $urandom;
                step(r, rnd[4*W-1:0], rnd[31]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
